// File: rtl/mp_row_mac_if.sv
// rtl/mp_row_mac_if.sv - RAM-side bus of the row MAC: A/Z read ports and result write port
interface mp_row_mac_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [ADDR_WIDTH-1:0] z_addr;
    logic [DATA_WIDTH-1:0] z_rdata;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    modport master (
        output a_addr, z_addr, r_we, r_addr, r_wdata,
        input  a_rdata, z_rdata
    );

    modport slave (
        input  a_addr, z_addr, r_we, r_addr, r_wdata,
        output a_rdata, z_rdata
    );
endinterface

// File: rtl/mp_row_mac.sv
// rtl/mp_row_mac.sv - word-serial row multiply-accumulate: R + carry*2^(N*W) = A*b + (acc ? Z : 0)
module mp_row_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] b_word,
    mp_row_mac_if.master          mem,
    output logic [DATA_WIDTH-1:0] carry_out,
    output logic                  busy,
    output logic                  done
);
    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic [DATA_WIDTH-1:0] b_lat;
    logic                  acc_lat;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] carry_q;
    logic                  r_we_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic [DATA_WIDTH-1:0] z_eff;
    logic [W2-1:0]         sum;

    // a*b + z + carry <= 2^(2W) - 1, so the double-width sum never overflows
    assign z_eff = acc_lat ? mem.z_rdata : '0;
    assign sum   = W2'(mem.a_rdata) * W2'(b_lat) + W2'(z_eff) + W2'(carry_q);

    assign mem.a_addr  = a_addr_q;
    assign mem.z_addr  = a_addr_q;
    assign mem.r_we    = r_we_q;
    assign mem.r_addr  = r_addr_q;
    assign mem.r_wdata = r_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_addr_q  <= '0;
            b_lat     <= '0;
            acc_lat   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            carry_q   <= '0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            carry_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // read data arrives one cycle after the address; register the word sum the cycle after that
            rd_valid <= (state == RUN);
            rd_idx   <= a_addr_q;
            r_we_q   <= rd_valid;
            if (rd_valid) begin
                r_addr_q  <= rd_idx;
                r_wdata_q <= sum[DATA_WIDTH-1:0];
                carry_q   <= sum[W2-1:DATA_WIDTH];
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        b_lat    <= b_word;
                        acc_lat  <= acc_en;
                        carry_q  <= '0;
                        a_addr_q <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (a_addr_q == LAST) begin
                        state <= DRAIN;
                    end else begin
                        a_addr_q <= a_addr_q + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (r_we_q && (r_addr_q == LAST)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= carry_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mp_row_mac.md
MP_ROW_MAC -- requirements
Module: mp_row_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width of the operands, results and carry.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the word-address width; a row is 2**ADDR_WIDTH words (32 words, 1024 bits).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request one row operation; it is sampled only in IDLE.
REQ-006 acc_en  input  1  SHALL select accumulate: 1 means Z is read and added, 0 means Z is treated as 0.
REQ-007 b_word  input  DATA_WIDTH  SHALL be the scalar multiplier, latched when start is accepted.
REQ-008 a_addr  output  ADDR_WIDTH  SHALL be the read address to the A-operand RAM.
REQ-009 a_rdata  input  DATA_WIDTH  SHALL be the A word, valid one cycle after a_addr.
REQ-010 z_addr  output  ADDR_WIDTH  SHALL be the read address to the Z accumulator RAM, always equal to a_addr.
REQ-011 z_rdata  input  DATA_WIDTH  SHALL be the Z word, valid one cycle after z_addr.
REQ-012 r_we  output  1  SHALL be the result-RAM write strobe.
REQ-013 r_addr  output  ADDR_WIDTH  SHALL be the result-RAM write address.
REQ-014 r_wdata  output  DATA_WIDTH  SHALL be the result word.
REQ-015 carry_out  output  DATA_WIDTH  SHALL be the final carry word (row word 32).
REQ-016 busy  output  1  SHALL be high while a row is in progress.
REQ-017 done  output  1  SHALL pulse high for one cycle at row completion.

Function
REQ-018 The block SHALL compute R + carry_out*2**(32*DATA_WIDTH) = A*b_word + (acc_en ? Z : 0), word-serially from word 0 (LSW) upward.
REQ-019 Per word i, the block SHALL form the 2*DATA_WIDTH-bit value a_rdata*b_lat + z + carry; the low half SHALL be R[i] and the high half SHALL be the next carry (no overflow is possible).
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-021 In IDLE, start=1 at edge T0 SHALL latch b_word and acc_en, clear the carry register to 0 and enter RUN.
REQ-022 RUN SHALL present a_addr=z_addr=i in cycle T0+1+i for i=0..31, then enter DRAIN.
REQ-023 The per-word product-sum SHALL be registered: r_we=1 with r_addr=i and r_wdata=R[i] in cycle T0+3+i.
REQ-024 DRAIN SHALL last until the write of word 31 (cycle T0+34), then enter DONE.
REQ-025 DONE SHALL assert done for cycle T0+35 only, then return to IDLE.
REQ-026 busy SHALL be 1 for cycles T0+1 through T0+34, and 0 otherwise.
REQ-027 carry_out SHALL be valid from cycle T0+35 and hold until the next accepted start.
REQ-028 start while busy or in DONE SHALL be ignored; changes to b_word or acc_en after acceptance SHALL have no effect.
REQ-029 When acc_en=0, z_rdata SHALL be ignored.
REQ-030 The address counter SHALL stop at 31 and never wrap within a row.
REQ-031 r_we SHALL be 0 in every cycle other than the 32 write cycles.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and clear to 0: r_we, busy, done, carry_out, r_addr, r_wdata, a_addr, z_addr, the carry register and the latched b.
REQ-033 Reset mid-row SHALL abort the row with no further writes and no done pulse; the next start after release SHALL run a complete row.

Verification
REQ-034 A[i]=0xFFFFFFFF, Z[i]=0xFFFFFFFF for all i, b=0xFFFFFFFF, acc_en=1 -> R[0]=0x00000000, R[1..31]=0xFFFFFFFF, carry_out=0xFFFFFFFF, done at T0+35.
REQ-035 A[0]=3, A[1..31]=0, b=5, acc_en=0, Z=garbage -> R[0]=15, R[1..31]=0, carry_out=0, exactly 32 writes.
REQ-036 A[0]=0x80000000, other words 0, b=2, acc_en=0 -> R[0]=0, R[1]=1, carry_out=0.
REQ-037 b=0, acc_en=1, Z[i]=i+1 -> R[i]=i+1, carry_out=0; a second start pulsed at T0+10 with a changed b_word -> ignored, results unchanged.
REQ-038 rst_n low at T0+10 -> r_we, busy and done are 0 immediately and no write occurs; a new start after release yields correct full-row results.
